// File: rtl/ifft_pkg.sv
// Shared definitions for the 8-point inverse-FFT coprocessor: command codes,
// controller states, conjugate-twiddle tables and the input bit-reversal helper.
package ifft_pkg;

    localparam int TW_W    = 16;
    localparam int TW_FRAC = 14;

    typedef enum logic [1:0] {
        OP_LOAD   = 2'd0,
        OP_CAL    = 2'd1,
        OP_EXPORT = 2'd2,
        OP_RSVD   = 2'd3
    } op_e;

    typedef enum logic [2:0] {
        S_LOAD,
        S_FULL,
        S_CALC,
        S_DONE,
        S_EXPORT
    } state_e;

    // W^-k = cos(2*pi*k/8) + j*sin(2*pi*k/8), k = 0..3, in Q(TW_FRAC)
    localparam logic signed [TW_W-1:0] COS_TW [0:3] = '{16'sd16384, 16'sd11585, 16'sd0, -16'sd11585};
    localparam logic signed [TW_W-1:0] SIN_TW [0:3] = '{16'sd0, 16'sd11585, 16'sd16384, 16'sd11585};

    function automatic logic [2:0] bitrev3(input logic [2:0] v);
        return {v[0], v[1], v[2]};
    endfunction

endpackage

// File: rtl/ifft_bfly.sv
// Combinational radix-2 butterfly with conjugate-twiddle multiply:
// x = a + b*W, y = a - b*W, W = cos + j*sin selected by i_k.
module ifft_bfly
    import ifft_pkg::*;
#(
    parameter int DATA_W = 32
) (
    input  logic signed [DATA_W-1:0] i_a_re,
    input  logic signed [DATA_W-1:0] i_a_im,
    input  logic signed [DATA_W-1:0] i_b_re,
    input  logic signed [DATA_W-1:0] i_b_im,
    input  logic        [1:0]        i_k,
    output logic signed [DATA_W-1:0] o_x_re,
    output logic signed [DATA_W-1:0] o_x_im,
    output logic signed [DATA_W-1:0] o_y_re,
    output logic signed [DATA_W-1:0] o_y_im
);

    localparam int PW = 2 * DATA_W;

    logic signed [TW_W-1:0]   w_c;
    logic signed [TW_W-1:0]   w_s;
    logic signed [PW-1:0]     w_prod_re;
    logic signed [PW-1:0]     w_prod_im;
    logic signed [DATA_W-1:0] w_t_re;
    logic signed [DATA_W-1:0] w_t_im;

    // Full-precision complex product, truncating rescale, then wrap-around add/sub
    always_comb begin
        w_c       = COS_TW[i_k];
        w_s       = SIN_TW[i_k];
        w_prod_re = PW'(i_b_re) * PW'(w_c) - PW'(i_b_im) * PW'(w_s);
        w_prod_im = PW'(i_b_re) * PW'(w_s) + PW'(i_b_im) * PW'(w_c);
        w_t_re    = DATA_W'(w_prod_re >>> TW_FRAC);
        w_t_im    = DATA_W'(w_prod_im >>> TW_FRAC);
        o_x_re    = i_a_re + w_t_re;
        o_x_im    = i_a_im + w_t_im;
        o_y_re    = i_a_re - w_t_re;
        o_y_im    = i_a_im - w_t_im;
    end

endmodule

// File: rtl/ifft8_unit.sv
// 8-point radix-2 DIT inverse-FFT coprocessor. Samples are loaded in
// bit-reversed slot order, transformed in place one butterfly per cycle,
// and exported in natural order with 1/8 scaling.
module ifft8_unit
    import ifft_pkg::*;
#(
    parameter int DATA_W = 32
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              cmd_valid,
    input  logic [1:0]        cmd_op,
    input  logic [DATA_W-1:0] cmd_data,
    output logic              cmd_ready,
    output logic              rsp_valid,
    output logic [DATA_W-1:0] rsp_data,
    output logic              busy,
    output logic              done,
    output logic              err
);

    state_e                   r_state;
    logic [3:0]               r_cnt;
    logic [1:0]               r_stage;
    logic [1:0]               r_bfly;
    logic signed [DATA_W-1:0] r_mem [0:15];

    logic                     w_accept;
    logic [2:0]               w_p;
    logic [2:0]               w_q;
    logic [1:0]               w_k;
    logic signed [DATA_W-1:0] w_x_re;
    logic signed [DATA_W-1:0] w_x_im;
    logic signed [DATA_W-1:0] w_y_re;
    logic signed [DATA_W-1:0] w_y_im;

    assign cmd_ready = (r_state != S_CALC);
    assign busy      = (r_state == S_CALC);
    assign done      = (r_state == S_DONE) || (r_state == S_EXPORT);
    assign w_accept  = cmd_valid && cmd_ready;

    // Butterfly pair (p, p+h) and twiddle index for the current stage/butterfly
    always_comb begin
        case (r_stage)
            2'd0: begin
                w_p = {r_bfly, 1'b0};
                w_q = {r_bfly, 1'b1};
                w_k = 2'd0;
            end
            2'd1: begin
                w_p = {r_bfly[1], 1'b0, r_bfly[0]};
                w_q = {r_bfly[1], 1'b1, r_bfly[0]};
                w_k = {r_bfly[0], 1'b0};
            end
            default: begin
                w_p = {1'b0, r_bfly};
                w_q = {1'b1, r_bfly};
                w_k = r_bfly;
            end
        endcase
    end

    ifft_bfly #(.DATA_W(DATA_W)) u_bfly (
        .i_a_re (r_mem[{w_p, 1'b0}]),
        .i_a_im (r_mem[{w_p, 1'b1}]),
        .i_b_re (r_mem[{w_q, 1'b0}]),
        .i_b_im (r_mem[{w_q, 1'b1}]),
        .i_k    (w_k),
        .o_x_re (w_x_re),
        .o_x_im (w_x_im),
        .o_y_re (w_y_re),
        .o_y_im (w_y_im)
    );

    // Command FSM, sample RAM and counters; illegal commands only pulse err
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state   <= S_LOAD;
            r_cnt     <= '0;
            r_stage   <= '0;
            r_bfly    <= '0;
            rsp_valid <= 1'b0;
            rsp_data  <= '0;
            err       <= 1'b0;
            for (int unsigned i = 0; i < 16; i++) begin
                r_mem[i] <= '0;
            end
        end else begin
            rsp_valid <= 1'b0;
            err       <= 1'b0;
            case (r_state)
                S_LOAD: begin
                    if (w_accept) begin
                        if (cmd_op == OP_LOAD) begin
                            r_mem[{bitrev3(r_cnt[3:1]), r_cnt[0]}] <= cmd_data;
                            r_cnt <= r_cnt + 4'd1;
                            if (r_cnt == 4'd15) begin
                                r_state <= S_FULL;
                            end
                        end else begin
                            err <= 1'b1;
                        end
                    end
                end
                S_FULL: begin
                    if (w_accept) begin
                        if (cmd_op == OP_CAL) begin
                            r_state <= S_CALC;
                            r_stage <= '0;
                            r_bfly  <= '0;
                        end else begin
                            err <= 1'b1;
                        end
                    end
                end
                S_CALC: begin
                    r_mem[{w_p, 1'b0}] <= w_x_re;
                    r_mem[{w_p, 1'b1}] <= w_x_im;
                    r_mem[{w_q, 1'b0}] <= w_y_re;
                    r_mem[{w_q, 1'b1}] <= w_y_im;
                    r_bfly <= r_bfly + 2'd1;
                    if (r_bfly == 2'd3) begin
                        if (r_stage == 2'd2) begin
                            r_stage <= '0;
                            r_state <= S_DONE;
                        end else begin
                            r_stage <= r_stage + 2'd1;
                        end
                    end
                end
                S_DONE, S_EXPORT: begin
                    if (w_accept) begin
                        if (cmd_op == OP_EXPORT) begin
                            rsp_data  <= r_mem[r_cnt] >>> 3;
                            rsp_valid <= 1'b1;
                            r_cnt     <= r_cnt + 4'd1;
                            r_state   <= (r_cnt == 4'd15) ? S_LOAD : S_EXPORT;
                        end else begin
                            err <= 1'b1;
                        end
                    end
                end
                default: r_state <= S_LOAD;
            endcase
        end
    end

endmodule

// File: tb/tb_ifft8_unit.sv
// Directed bench for ifft8_unit: expected export words are queued when an
// EXPORT is issued and compared when rsp_valid appears.
module tb_ifft8_unit;
    import ifft_pkg::*;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        cmd_valid = 1'b0;
    logic [1:0]  cmd_op = 2'd0;
    logic [31:0] cmd_data = '0;
    logic        cmd_ready;
    logic        rsp_valid;
    logic [31:0] rsp_data;
    logic        busy;
    logic        done;
    logic        err;

    int          n_checks = 0;
    int          n_fail = 0;
    logic [31:0] exp_q [$];

    int imp_in  [16] = '{1000, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0};
    int imp_out [16] = '{125, 0, 125, 0, 125, 0, 125, 0, 125, 0, 125, 0, 125, 0, 125, 0};
    int dc_in   [16] = '{8000, 0, 8000, 0, 8000, 0, 8000, 0, 8000, 0, 8000, 0, 8000, 0, 8000, 0};
    int dc_out  [16] = '{8000, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0};
    int tone_in [16] = '{0, 0, 800, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0};
    int tone_out[16] = '{100, 0, 70, 70, 0, 100, -71, 70, -100, 0, -71, -71, 0, -100, 70, -71};
    int b2b_in  [16] = '{-1000, 2000, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0};
    int b2b_out [16] = '{-125, 250, -125, 250, -125, 250, -125, 250, -125, 250, -125, 250, -125, 250, -125, 250};

    ifft8_unit #(.DATA_W(32)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .cmd_valid (cmd_valid),
        .cmd_op    (cmd_op),
        .cmd_data  (cmd_data),
        .cmd_ready (cmd_ready),
        .rsp_valid (rsp_valid),
        .rsp_data  (rsp_data),
        .busy      (busy),
        .done      (done),
        .err       (err)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        n_checks++;
        assert (obs === expv) else begin
            n_fail++;
            $error("FAIL %s observed=%0d expected=%0d", tag, $signed(obs), $signed(expv));
        end
    endtask

    // Response scoreboard: every rsp_valid pulse must match the oldest queued word
    always @(posedge clk) begin
        #1;
        if (rst_n && rsp_valid) begin
            chk("rsp_expected", 32'(exp_q.size() != 0), 32'd1);
            if (exp_q.size() != 0) begin
                chk("rsp_data", rsp_data, exp_q.pop_front());
            end
        end
    end

    // Present one command, wait (bounded) for acceptance, check the err pulse
    task automatic send(input logic [1:0] op, input logic [31:0] data, input logic exp_err);
        int n = 0;
        @(negedge clk);
        cmd_valid = 1'b1;
        cmd_op    = op;
        cmd_data  = data;
        while (!cmd_ready && n < 50) begin
            @(negedge clk);
            n++;
        end
        chk("accept_timeout", 32'(n < 50), 32'd1);
        @(posedge clk);
        #1;
        cmd_valid = 1'b0;
        chk("err", 32'(err), 32'(exp_err));
    endtask

    task automatic load_all(input int v [16]);
        for (int i = 0; i < 16; i++) send(OP_LOAD, v[i], 1'b0);
    endtask

    task automatic do_cal();
        int n = 0;
        send(OP_CAL, 32'd0, 1'b0);
        chk("busy_after_cal", 32'(busy), 32'd1);
        chk("ready_after_cal", 32'(cmd_ready), 32'd0);
        while (!cmd_ready && n < 40) begin
            @(posedge clk);
            #1;
            n++;
        end
        chk("ready_low_cycles", n, 32'd12);
        chk("done_after_calc", 32'(done), 32'd1);
        chk("busy_after_calc", 32'(busy), 32'd0);
    endtask

    task automatic export_all(input int v [16]);
        for (int i = 0; i < 16; i++) begin
            exp_q.push_back(v[i]);
            send(OP_EXPORT, 32'd0, 1'b0);
        end
        #1;
        chk("queue_drained", exp_q.size(), 32'd0);
        chk("done_cleared", 32'(done), 32'd0);
    endtask

    initial begin
        // Reset values
        repeat (2) @(negedge clk);
        chk("rst_cmd_ready", 32'(cmd_ready), 32'd1);
        chk("rst_rsp_valid", 32'(rsp_valid), 32'd0);
        chk("rst_rsp_data", rsp_data, 32'd0);
        chk("rst_busy", 32'(busy), 32'd0);
        chk("rst_done", 32'(done), 32'd0);
        chk("rst_err", 32'(err), 32'd0);
        rst_n = 1'b1;

        // Impulse
        load_all(imp_in);
        do_cal();
        export_all(imp_out);

        // DC bin
        load_all(dc_in);
        do_cal();
        export_all(dc_out);

        // Single tone, then rsp_data must hold the last exported word
        load_all(tone_in);
        do_cal();
        export_all(tone_out);
        repeat (3) @(posedge clk);
        #1;
        chk("rsp_data_held", rsp_data, 32'(-71));
        chk("rsp_valid_idle", 32'(rsp_valid), 32'd0);

        // Protocol errors: reserved op, early CAL, early EXPORT, overflow LOAD
        send(OP_RSVD, 32'd0, 1'b1);
        send(OP_EXPORT, 32'd0, 1'b1);
        for (int i = 0; i < 5; i++) send(OP_LOAD, imp_in[i], 1'b0);
        send(OP_CAL, 32'd0, 1'b1);
        for (int i = 5; i < 16; i++) send(OP_LOAD, imp_in[i], 1'b0);
        send(OP_EXPORT, 32'd0, 1'b1);
        send(OP_LOAD, 32'd9999, 1'b1);
        chk("full_not_done", 32'(done), 32'd0);
        do_cal();
        send(OP_CAL, 32'd0, 1'b1);
        send(OP_LOAD, 32'd5, 1'b1);
        export_all(imp_out);

        // Reset in the middle of the computation
        load_all(tone_in);
        send(OP_CAL, 32'd0, 1'b0);
        repeat (6) @(posedge clk);
        #2;
        rst_n = 1'b0;
        #1;
        chk("midrst_cmd_ready", 32'(cmd_ready), 32'd1);
        chk("midrst_rsp_valid", 32'(rsp_valid), 32'd0);
        chk("midrst_rsp_data", rsp_data, 32'd0);
        chk("midrst_busy", 32'(busy), 32'd0);
        chk("midrst_done", 32'(done), 32'd0);
        chk("midrst_err", 32'(err), 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        load_all(imp_in);
        do_cal();
        export_all(imp_out);

        // Back-to-back: next LOAD issued in the cycle after the 16th EXPORT
        load_all(b2b_in);
        do_cal();
        export_all(b2b_out);

        repeat (2) @(posedge clk);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL global_timeout observed=running expected=finished");
        $fatal(1, "simulation time limit reached");
    end

endmodule
